// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a line-oriented backing memory. Hits complete combinationally in the
// request cycle; misses run a WRITEBACK/ALLOCATE sequence over a valid/ready
// request channel and stall the CPU through is_ready/is_output_valid.
// Optional build macro: DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_direct_mapped #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_rw,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_write,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_wdata,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = 28 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t                state;
  logic [NUM_SETS-1:0]   valid_bits;
  logic [NUM_SETS-1:0]   dirty_bits;
  logic [TAG_BITS-1:0]   tag_mem [NUM_SETS];
  logic [127:0]          data_mem [NUM_SETS];

  logic [IDX_BITS-1:0]   index;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            word_sel;
  logic                  hit;
  logic                  lookup_hit;
  logic                  lookup_miss;
  logic                  resp_fire;
  logic                  unused_addr_bits;

  assign index            = addr[4 +: IDX_BITS];
  assign tag              = addr[31 -: TAG_BITS];
  assign word_sel         = addr[3:2];
  assign unused_addr_bits = ^addr[1:0];

  // A response only counts once our request has been accepted (valid dropped)
  assign hit         = valid_bits[index] && (tag_mem[index] == tag);
  assign lookup_hit  = (state == IDLE) && is_input_valid && hit;
  assign lookup_miss = (state == IDLE) && is_input_valid && !hit;
  assign resp_fire   = (state != IDLE) && !mem_req_valid && mem_resp_valid;

  assign is_ready        = (state == IDLE);
  assign is_output_valid = lookup_hit;
  assign is_hit          = lookup_hit;
  assign dout            = (lookup_hit && !mem_rw) ? data_mem[index][{word_sel, 5'b00000} +: 32] : '0;
  assign mem_req_write   = (state == WRITEBACK);

  // Memory request address/data follow the miss state; fields stay stable
  // because the CPU holds addr and the victim set is not touched meanwhile
  always_comb begin
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_req_addr  = {tag_mem[index], index, 4'b0000};
        mem_req_wdata = data_mem[index];
      end
      ALLOCATE: mem_req_addr = {addr[31:4], 4'b0000};
      default: ;
    endcase
  end

  // Lookup/miss controller: state, request-valid handshake and valid/dirty bits
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      valid_bits    <= '0;
      dirty_bits    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lookup_hit && mem_rw) begin
            dirty_bits[index] <= 1'b1;
          end else if (lookup_miss) begin
            mem_req_valid <= 1'b1;
            state <= (valid_bits[index] && dirty_bits[index]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
          end else if (resp_fire) begin
            dirty_bits[index] <= 1'b0;
            mem_req_valid     <= 1'b1;
            state             <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
          end else if (resp_fire) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
            state             <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: word writes on write hits, whole-line refill on fill response
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (lookup_hit && mem_rw) begin
        data_mem[index][{word_sel, 5'b00000} +: 32] <= din;
      end
      if ((state == ALLOCATE) && resp_fire) begin
        data_mem[index] <= mem_resp_rdata;
        tag_mem[index]  <= tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic just_filled;

  // Hit/miss statistics; the hit right after a refill is the replayed miss
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count   <= '0;
      miss_count  <= '0;
      just_filled <= 1'b0;
    end else begin
      just_filled <= (state == ALLOCATE) && resp_fire;
      if (lookup_miss) begin
        miss_count <= miss_count + 32'd1;
      end
      if (lookup_hit && !just_filled) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped: directed scenarios followed by
// randomized CPU traffic, checked against a behavioural cache + memory model.
module tb_dcache_direct_mapped;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: per-set cache contents plus backing memory of lines
  logic         m_valid [16];
  logic         m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [127:0] backing [int unsigned];
  logic [127:0] last_wb_wdata;
  logic [31:0]  last_wb_addr;
  logic [31:0]  got;

  dcache_direct_mapped dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
    .dout(dout), .is_hit(is_hit), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] initLine(input logic [31:0] la);
    return {la ^ 32'h5A5A000C, la ^ 32'h5A5A0008, la ^ 32'h5A5A0004, la ^ 32'h5A5A0000};
  endfunction

  function automatic logic [127:0] getBacking(input logic [31:0] la);
    if (backing.exists(la)) return backing[la];
    return initLine(la);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_ready", is_ready, 1'b1);
    checkOutput("rst_ov", is_output_valid, 1'b0);
    checkOutput("rst_hit", is_hit, 1'b0);
    checkOutput("rst_dout", dout, 32'h0);
    checkOutput("rst_reqv", mem_req_valid, 1'b0);
  endtask

  // Memory side of one line request: optional ready stall, accept, respond
  task automatic serveRequest(input logic exp_write, input logic [31:0] exp_addr,
                              input logic [127:0] exp_wdata, input logic [127:0] resp, input int stall);
    int cycles = 0;
    while (!mem_req_valid && cycles < 20) begin
      @(negedge clk); #1; cycles++;
    end
    checkOutput("req_valid", mem_req_valid, 1'b1);
    checkOutput("req_write", mem_req_write, exp_write);
    checkOutput("req_addr", mem_req_addr, exp_addr);
    if (exp_write) begin
      checkOutput("req_wdata", mem_req_wdata, exp_wdata);
      last_wb_wdata = mem_req_wdata;
      last_wb_addr  = mem_req_addr;
    end
    checkOutput("busy_ready", is_ready, 1'b0);
    checkOutput("busy_ov", is_output_valid, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput("hold_valid", mem_req_valid, 1'b1);
      checkOutput("hold_addr", mem_req_addr, exp_addr);
      checkOutput("hold_write", mem_req_write, exp_write);
      checkOutput("hold_ready", is_ready, 1'b0);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    checkOutput("req_drop", mem_req_valid, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = resp;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
  endtask

  // One CPU access, completed through any miss handling the model predicts
  task automatic applyStimulus(input logic [31:0] a, input logic rw, input logic [31:0] d,
                               input int stall, output logic [31:0] observed);
    int          idx = int'(a[7:4]);
    int          w   = int'(a[3:2]);
    logic [23:0] tg  = a[31:8];
    logic [31:0] la  = {a[31:4], 4'b0000};
    logic        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    logic [127:0] line;
    @(negedge clk);
    is_input_valid = 1'b1; addr = a; mem_rw = rw; din = d;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    if (!exp_hit) begin
      checkOutput("miss_ov", is_output_valid, 1'b0);
      checkOutput("miss_ready", is_ready, 1'b1);
      @(negedge clk); #1;
      if (m_valid[idx] && m_dirty[idx]) begin
        serveRequest(1'b1, {m_tag[idx], 4'(idx), 4'b0000}, m_data[idx], {$urandom, $urandom, $urandom, $urandom}, stall);
        backing[{m_tag[idx], 4'(idx), 4'b0000}] = m_data[idx];
        m_dirty[idx] = 1'b0;
      end
      line = getBacking(la);
      serveRequest(1'b0, la, '0, line, stall);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = line;
    end
    checkOutput("done_ov", is_output_valid, 1'b1);
    checkOutput("done_hit", is_hit, 1'b1);
    checkOutput("done_reqv", mem_req_valid, 1'b0);
    if (!rw) checkOutput("done_dout", dout, m_data[idx][w*32 +: 32]);
    observed = dout;
    if (rw) begin
      m_data[idx][w*32 +: 32] = d;
      m_dirty[idx] = 1'b1;
    end
    @(negedge clk);
    is_input_valid = 1'b0;
  endtask

  // Cycle with no CPU request: everything quiet apart from is_ready
  task automatic idleCycle();
    @(negedge clk);
    is_input_valid = 1'b0; addr = $urandom; mem_rw = 1'($urandom_range(0, 1));
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checkOutput("idle_ov", is_output_valid, 1'b0);
    checkOutput("idle_hit", is_hit, 1'b0);
    checkOutput("idle_dout", dout, 32'h0);
    checkOutput("idle_reqv", mem_req_valid, 1'b0);
    checkOutput("idle_ready", is_ready, 1'b1);
  endtask

  initial begin
    logic [23:0] rtag;
    logic [31:0] raddr;
    int          tsel;
    reset = 1'b1; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    last_wb_wdata = '0; last_wb_addr = '0;
    backing[32'h40] = 128'h33333333_22222222_11111111_00000000;

    resetDut();

    applyStimulus(32'h40, 1'b0, 32'h0, 1, got);
    checkOutput("tp1_dout40", got, 32'h00000000);
    applyStimulus(32'h48, 1'b0, 32'h0, 0, got);
    checkOutput("tp1_dout48", got, 32'h22222222);
    applyStimulus(32'h44, 1'b1, 32'hDEADBEEF, 0, got);
    applyStimulus(32'h44, 1'b0, 32'h0, 0, got);
    checkOutput("tp2_dout44", got, 32'hDEADBEEF);
    applyStimulus(32'h140, 1'b0, 32'h0, 5, got);
    checkOutput("tp3_wb_addr", last_wb_addr, 32'h40);
    checkOutput("tp3_wb_word1", last_wb_wdata[63:32], 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    checkOutput("stats_miss", miss_count, 32'd2);
    checkOutput("stats_hit", hit_count, 32'd3);
`endif

    // Reset while a fill is outstanding, with its response arriving late
    @(negedge clk);
    is_input_valid = 1'b1; addr = 32'h50; mem_rw = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_mid_reqv", mem_req_valid, 1'b1);
    @(negedge clk); mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
    reset = 1'b1; is_input_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = {4{32'hBADBAD00}};
    @(negedge clk); reset = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_mid_ready", is_ready, 1'b1);
    checkOutput("rst_mid_reqv0", mem_req_valid, 1'b0);
    checkOutput("rst_mid_ov", is_output_valid, 1'b0);
    @(negedge clk); mem_resp_valid = 1'b0;
    #1;
    checkOutput("rst_mid_ready2", is_ready, 1'b1);
    applyStimulus(32'h40, 1'b0, 32'h0, 0, got);
    applyStimulus(32'h50, 1'b0, 32'h0, 0, got);

    // Randomized traffic with heavy set aliasing
    for (int n = 0; n < 250; n++) begin
      tsel  = $urandom_range(0, 4);
      rtag  = (tsel == 4) ? 24'hFFFFFF : 24'(tsel);
      raddr = {rtag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      applyStimulus(raddr, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5), got);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
